// File: rtl/leaf_task_dispatcher.sv
// Round-robin dispatcher: one held task word is sent to exactly one enabled leaf.
// Latency: a word loaded on edge k is presented to its leaf from cycle k+1; 1 word/cycle sustained.
// Backpressure: in_ready stalls while the held word waits on its target leaf or when no leaf is enabled.
module leaf_task_dispatcher #(
    parameter int DATA_W = 8,
    parameter int N_LEAF = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [N_LEAF-1:0] leaf_en,
    output logic [N_LEAF-1:0] out_valid,
    input  logic [N_LEAF-1:0] out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [CNT_W-1:0]  dispatched_count
);
    localparam int IDX_W = $clog2(N_LEAF);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  hold_data;
    logic [IDX_W-1:0]   target;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   sel_next;
    logic               any_en;
    logic               accept;
    logic               load;

    assign any_en = |leaf_en;

    // First enabled leaf at or after ptr, wrapping modulo N_LEAF.
    always_comb begin
        logic [IDX_W:0] cand;
        logic           found;
        sel   = ptr;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_LEAF; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_LEAF)) begin
                cand = cand - (IDX_W+1)'(N_LEAF);
            end
            if (!found && leaf_en[cand[IDX_W-1:0]]) begin
                sel   = cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign sel_next = (sel == IDX_W'(N_LEAF-1)) ? '0 : sel + 1'b1;

    assign accept    = (state_q == FULL) && out_ready[target];
    assign in_ready  = any_en && ((state_q == EMPTY) || accept);
    assign load      = in_valid && in_ready;
    assign out_valid = (state_q == FULL) ? ({{(N_LEAF-1){1'b0}}, 1'b1} << target) : '0;
    assign out_data  = hold_data;
    assign busy      = (state_q == FULL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (load) state_d = FULL;
            FULL:    if (accept && !load) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Target and word are frozen while FULL; ptr moves only when a word is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data        <= '0;
            target           <= '0;
            ptr              <= '0;
            dispatched_count <= '0;
        end else begin
            if (load) begin
                hold_data <= in_data;
                target    <= sel;
                ptr       <= sel_next;
            end
            if (accept) begin
                dispatched_count <= dispatched_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_leaf_task_dispatcher.sv
// Randomized and directed bench for leaf_task_dispatcher with a queue scoreboard.
module tb_leaf_task_dispatcher;
    localparam int DATA_W = 8;
    localparam int N_LEAF = 5;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [N_LEAF-1:0] leaf_en;
    logic [N_LEAF-1:0] out_valid;
    logic [N_LEAF-1:0] out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic [CNT_W-1:0]  dispatched_count;

    leaf_task_dispatcher #(.DATA_W(DATA_W), .N_LEAF(N_LEAF), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .leaf_en(leaf_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .dispatched_count(dispatched_count)
    );

    always #5 clk = ~clk;

    typedef struct { int leaf; logic [DATA_W-1:0] data; } exp_t;
    exp_t sb[$];
    int   hist[$];

    int checks = 0;
    int passes = 0;

    // Reference state: one slot, round-robin pointer, transfer count.
    bit               m_full;
    int               m_tgt;
    int               m_ptr;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int pick_leaf(input int start, input logic [N_LEAF-1:0] en);
        for (int k = 0; k < N_LEAF; k++)
            if (en[(start + k) % N_LEAF]) return (start + k) % N_LEAF;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_full = 0; m_tgt = 0; m_ptr = 0; m_data = '0; m_cnt = '0;
            sb.delete();
        end else begin
            bit exp_rdy, fire, ld;
            int s;
            exp_rdy = (leaf_en != 0) && (!m_full || out_ready[m_tgt]);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(m_full));
            chk("out_valid", 32'(out_valid), m_full ? (32'd1 << m_tgt) : 32'd0);
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("count", 32'(dispatched_count), 32'(m_cnt));
            fire = m_full && out_ready[m_tgt];
            ld   = in_valid && exp_rdy;
            if (fire) m_cnt = m_cnt + 1'b1;
            if (ld) begin
                s = pick_leaf(m_ptr, leaf_en);
                sb.push_back('{leaf: s, data: in_data});
                m_data = in_data;
                m_tgt  = s;
                m_ptr  = (s + 1) % N_LEAF;
                m_full = 1;
            end else if (fire) begin
                m_full = 0;
            end
        end
    end

    // Monitor: every completed leaf handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && ((out_valid & out_ready) != 0)) begin
            int idx;
            exp_t e;
            idx = -1;
            for (int i = 0; i < N_LEAF; i++) if (out_valid[i]) idx = i;
            hist.push_back(idx);
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL sb_underflow: transfer to leaf %0d with nothing expected", idx);
            end else begin
                e = sb.pop_front();
                chk("xfer_leaf", 32'(out_valid), 32'd1 << e.leaf);
                chk("xfer_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(dispatched_count), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        in_valid = 0; in_data = '0; leaf_en = '1; out_ready = '1; rst_n = 1'b1;
        #2;
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back words across all five leaves.
        hist.delete();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_data = 8'h10 + 8'(i); step();
        end
        in_valid = 0; step(); step();
        chk("t1_count", 32'(dispatched_count), 32'd5);
        chk("t1_n", 32'(hist.size()), 32'd5);
        for (int i = 0; i < 5 && i < hist.size(); i++) chk("t1_order", 32'(hist[i]), 32'(i));

        // Sparse enable mask.
        hist.delete();
        leaf_en = 5'b10101;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = 8'h20 + 8'(i); step();
        end
        in_valid = 0; step(); step();
        chk("t2_n", 32'(hist.size()), 32'd4);
        if (hist.size() == 4) begin
            chk("t2_l0", 32'(hist[0]), 32'd0);
            chk("t2_l1", 32'(hist[1]), 32'd2);
            chk("t2_l2", 32'(hist[2]), 32'd4);
            chk("t2_l3", 32'(hist[3]), 32'd0);
        end

        // Stall on leaf 1 (ptr is now 1).
        leaf_en = 5'b11111; out_ready = 5'b11101;
        in_valid = 1; in_data = 8'hAA; step();
        in_data = 8'hBB;
        repeat (6) step();
        chk("t3_hold_data", 32'(out_data), 32'hAA);
        chk("t3_hold_valid", 32'(out_valid), 32'b00010);
        out_ready = '1; step();
        in_valid = 0; step(); step();

        // No enabled leaf, then disable the target while it is held.
        leaf_en = '0; in_valid = 1; in_data = 8'h33;
        repeat (8) step();
        leaf_en = '1; out_ready = '0; in_data = 8'hCC; step();
        in_valid = 0; leaf_en = '0; step(); step();
        out_ready = '1; step(); step();
        leaf_en = '1;

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 8'($urandom);
            leaf_en   = ($urandom_range(0, 15) == 0) ? '0 : 5'($urandom);
            out_ready = 5'($urandom);
            step();
        end
        in_valid = 0; leaf_en = '1; out_ready = '1; step(); step();

        // Counter wrap.
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            in_valid = 1; in_data = 8'(i); step();
        end
        in_valid = 0; step();
        chk("wrap_max", 32'(dispatched_count), 32'hFFFF);
        in_valid = 1; in_data = 8'h5A; step();
        in_valid = 0; step();
        chk("wrap_zero", 32'(dispatched_count), 32'h0);

        // Reset while a word is held.
        out_ready = '0; in_valid = 1; in_data = 8'h55; step();
        in_valid = 0; step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        do_reset();
        out_ready = '1; hist.delete();
        in_valid = 1; in_data = 8'h66; step();
        in_valid = 0; step(); step();
        chk("post_rst_n", 32'(hist.size()), 32'd1);
        if (hist.size() > 0) chk("post_rst_leaf", 32'(hist[0]), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
